// File: rtl/key_scan_4x4_if.sv
// key_scan_4x4_if: matrix lines and decoded key outputs of the 4x4 key scanner
interface key_scan_4x4_if;
    logic [3:0] col;
    logic [3:0] row;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_down;
    logic       multi_err;
    modport master(input col, output row, key_code, key_valid, key_down, multi_err);
    modport slave(output col, input row, key_code, key_valid, key_down, multi_err);
endinterface

// File: rtl/key_scan_4x4.sv
// key_scan_4x4: scans an active-low 4x4 key matrix and debounces over whole frames
module key_scan_4x4 #(
    parameter int ROW_DWELL = 4,
    parameter int DEBOUNCE  = 4
) (
    input logic            clk_1k,
    input logic            rst_n,
    key_scan_4x4_if.master bus
);
    localparam int DW = $clog2(ROW_DWELL);
    localparam int CW = $clog2(DEBOUNCE + 1);

    typedef enum logic [1:0] {IDLE, PRESS_CHK, HELD, RELEASE_CHK} state_t;

    state_t          state, state_n;
    logic [3:0]      c1, c2;
    logic [1:0]      r;
    logic [DW-1:0]   d;
    logic [1:0]      acc_n, tot, col_first;
    logic [3:0]      acc_code, first, cand, cand_n, code_n;
    logic [2:0]      hits, sum;
    logic [CW-1:0]   cnt, cnt_n;
    logic            sample, frame_end, none, one, multi, valid_n, down_n, err_n;

    // Frame result folds the current row sample into the running accumulators
    always_comb begin
        sample    = d == DW'(ROW_DWELL - 1);
        frame_end = sample && r == 2'd3;
        hits      = 3'(!c2[0]) + 3'(!c2[1]) + 3'(!c2[2]) + 3'(!c2[3]);
        col_first = !c2[0] ? 2'd0 : !c2[1] ? 2'd1 : !c2[2] ? 2'd2 : 2'd3;
        sum       = {1'b0, acc_n} + hits;
        tot       = sum >= 3'd2 ? 2'd2 : sum[1:0];
        first     = acc_n == 2'd0 ? {r, col_first} : acc_code;
        none      = tot == 2'd0;
        one       = tot == 2'd1;
        multi     = tot == 2'd2;
    end

    always_ff @(posedge clk_1k) begin
        if (!rst_n) begin
            c1       <= 4'b1111;
            c2       <= 4'b1111;
            r        <= 2'd0;
            d        <= '0;
            bus.row  <= 4'b1110;
            acc_n    <= 2'd0;
            acc_code <= 4'd0;
        end else begin
            c1 <= bus.col;
            c2 <= c1;
            d  <= sample ? '0 : d + 1'b1;
            if (sample) begin
                r        <= r + 2'd1;
                bus.row  <= ~(4'b0001 << 2'(r + 2'd1));
                acc_n    <= frame_end ? 2'd0 : tot;
                acc_code <= frame_end ? 4'd0 : first;
            end
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        cand_n  = cand;
        code_n  = bus.key_code;
        down_n  = bus.key_down;
        valid_n = 1'b0;
        err_n   = 1'b0;
        if (frame_end) begin
            case (state)
                IDLE: begin
                    if (one) begin
                        cand_n  = first;
                        cnt_n   = CW'(1);
                        state_n = PRESS_CHK;
                    end else begin
                        err_n = multi;
                    end
                end
                PRESS_CHK: begin
                    if (one && first == cand) begin
                        cnt_n = cnt + 1'b1;
                        if (cnt_n == CW'(DEBOUNCE)) begin
                            state_n = HELD;
                            code_n  = cand;
                            down_n  = 1'b1;
                            valid_n = 1'b1;
                        end
                    end else if (one) begin
                        cand_n = first;
                        cnt_n  = CW'(1);
                    end else begin
                        state_n = IDLE;
                        cnt_n   = '0;
                        err_n   = multi;
                    end
                end
                HELD: begin
                    if (none) begin
                        state_n = RELEASE_CHK;
                        cnt_n   = CW'(1);
                    end else begin
                        err_n = multi;
                    end
                end
                RELEASE_CHK: begin
                    if (none) begin
                        cnt_n = cnt + 1'b1;
                        if (cnt_n == CW'(DEBOUNCE)) begin
                            state_n = IDLE;
                            down_n  = 1'b0;
                        end
                    end else begin
                        state_n = HELD;
                        cnt_n   = '0;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_1k) begin
        if (!rst_n) begin
            state         <= IDLE;
            cnt           <= '0;
            cand          <= 4'd0;
            bus.key_code  <= 4'd0;
            bus.key_down  <= 1'b0;
            bus.key_valid <= 1'b0;
            bus.multi_err <= 1'b0;
        end else begin
            state         <= state_n;
            cnt           <= cnt_n;
            cand          <= cand_n;
            bus.key_code  <= code_n;
            bus.key_down  <= down_n;
            bus.key_valid <= valid_n;
            bus.multi_err <= err_n;
        end
    end
endmodule

// File: tb/tb_key_scan_4x4.sv
// tb_key_scan_4x4: frame-level key matrix model driving key_scan_4x4 against a run-length reference
module tb_key_scan_4x4;
    localparam int RD = 4;
    localparam int DB = 4;

    logic        clk_1k = 1'b0;
    logic        rst_n  = 1'b0;
    logic [15:0] keys   = 16'h0;
    int          checks = 0;
    int          errors = 0;
    bit          m_down, e_valid, e_err;
    logic [3:0]  m_code;
    int          run_val, run_len;
    int          o_valid, o_err;
    logic [3:0]  o_rows [16];

    key_scan_4x4_if ifc();

    function automatic logic [3:0] matrix(input logic [3:0] rw, input logic [15:0] k);
        logic [3:0] c;
        c = 4'hf;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                if (!rw[i] && k[i*4+j]) c[j] = 1'b0;
        return c;
    endfunction

    assign ifc.col = matrix(ifc.row, keys);

    key_scan_4x4 #(.ROW_DWELL(RD), .DEBOUNCE(DB)) dut (
        .clk_1k(clk_1k),
        .rst_n (rst_n),
        .bus   (ifc.master)
    );

    always #5 clk_1k = ~clk_1k;

    task automatic model_reset();
        m_down  = 1'b0;
        m_code  = 4'd0;
        run_val = 16;
        run_len = 0;
    endtask

    // Frame result as a value: 0..15 single key, 16 nothing, 17 several keys
    task automatic model_frame(input logic [15:0] k);
        int res, prev;
        res  = $countones(k) == 0 ? 16 : $countones(k) > 1 ? 17 : $clog2(k);
        prev = run_val;
        if (res == run_val) run_len++;
        else begin
            run_val = res;
            run_len = 1;
        end
        e_valid = 1'b0;
        e_err   = 1'b0;
        if (!m_down) begin
            e_err = res == 17;
            if (res < 16 && run_len == DB) begin
                e_valid = 1'b1;
                m_down  = 1'b1;
                m_code  = 4'(res);
            end
        end else begin
            e_err = res == 17 && prev != 16;
            if (res == 16 && run_len == DB) m_down = 1'b0;
        end
    endtask

    task automatic frame(input logic [15:0] k);
        keys    = k;
        o_valid = 0;
        o_err   = 0;
        for (int i = 0; i < 16; i++) begin
            @(posedge clk_1k);
            #1;
            o_rows[i] = ifc.row;
            o_valid  += int'(ifc.key_valid);
            o_err    += int'(ifc.multi_err);
        end
        model_frame(k);
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk_1k);
        #1 rst_n = 1'b1;
        keys = 16'h0040;
        repeat (20 + $urandom_range(0, 30)) @(posedge clk_1k);
        #1 rst_n = 1'b0;
        keys = 16'h0;
        repeat (3) @(posedge clk_1k);
        #1;
        checks += 5;
        if (ifc.row !== 4'b1110) begin errors++; $display("FAIL reset_row: got %b want 1110", ifc.row); end
        if (ifc.key_code !== 4'd0) begin errors++; $display("FAIL reset_code: got %0d want 0", ifc.key_code); end
        if (ifc.key_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", ifc.key_valid); end
        if (ifc.key_down !== 1'b0) begin errors++; $display("FAIL reset_down: got %b want 0", ifc.key_down); end
        if (ifc.multi_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", ifc.multi_err); end
        rst_n = 1'b1;
        model_reset();
        frame(16'h0);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (o_rows[i] !== (i < 3 ? 4'b1110 : 4'b1101)) begin
                errors++;
                $display("FAIL reset_dwell[%0d]: got %b want %b", i, o_rows[i], i < 3 ? 4'b1110 : 4'b1101);
            end
        end
    endtask

    task automatic test_idle();
        logic [3:0] want;
        for (int f = 0; f < 3; f++) begin
            frame(16'h0);
            for (int i = 0; i < 16; i++) begin
                want = ~(4'b0001 << (((i + 1) / RD) % 4));
                checks++;
                if (o_rows[i] !== want) begin errors++; $display("FAIL idle_row[%0d]: got %b want %b", i, o_rows[i], want); end
            end
            checks++;
            if (o_valid != 0 || o_err != 0) begin errors++; $display("FAIL idle_pulse: got valid %0d err %0d want 0 0", o_valid, o_err); end
        end
    endtask

    task automatic test_press();
        int total = 0;
        for (int f = 0; f < 17; f++) begin
            frame(16'h0040);
            total += o_valid;
            checks++;
            if (o_valid != int'(e_valid)) begin errors++; $display("FAIL press_valid[%0d]: got %0d want %0d", f, o_valid, e_valid); end
            if (f == 3) begin
                checks += 2;
                if (o_valid != 1) begin errors++; $display("FAIL press_latency: got %0d pulses want 1", o_valid); end
                if (ifc.key_code !== 4'd6) begin errors++; $display("FAIL press_code: got %0d want 6", ifc.key_code); end
            end
        end
        checks += 2;
        if (total != 1) begin errors++; $display("FAIL press_total: got %0d want 1", total); end
        if (ifc.key_down !== 1'b1) begin errors++; $display("FAIL press_down: got %b want 1", ifc.key_down); end
    endtask

    task automatic test_bounce();
        logic [15:0] pat [8] = '{16'h40, 16'h40, 16'h0, 16'h40, 16'h40, 16'h40, 16'h40, 16'h40};
        int total = 0;
        for (int f = 0; f < 6 && m_down; f++) frame(16'h0);
        checks++;
        if (ifc.key_down !== 1'b0) begin errors++; $display("FAIL bounce_idle: got %b want 0", ifc.key_down); end
        for (int f = 0; f < 8; f++) begin
            frame(pat[f]);
            total += o_valid;
            checks++;
            if (o_valid != (f == 6 ? 1 : 0)) begin errors++; $display("FAIL bounce_valid[%0d]: got %0d want %0d", f, o_valid, f == 6); end
        end
        checks += 2;
        if (total != 1) begin errors++; $display("FAIL bounce_total: got %0d want 1", total); end
        if (ifc.key_code !== 4'd6) begin errors++; $display("FAIL bounce_code: got %0d want 6", ifc.key_code); end
    endtask

    task automatic test_release();
        logic [15:0] pat [7] = '{16'h0, 16'h0, 16'h40, 16'h0, 16'h0, 16'h0, 16'h0};
        for (int f = 0; f < 7; f++) begin
            frame(pat[f]);
            checks += 3;
            if (ifc.key_down !== (f < 6 ? 1'b1 : 1'b0)) begin errors++; $display("FAIL release_down[%0d]: got %b want %b", f, ifc.key_down, f < 6); end
            if (ifc.key_code !== 4'd6) begin errors++; $display("FAIL release_code[%0d]: got %0d want 6", f, ifc.key_code); end
            if (o_valid != 0) begin errors++; $display("FAIL release_valid[%0d]: got %0d want 0", f, o_valid); end
        end
    endtask

    task automatic test_multi();
        int total = 0;
        for (int f = 0; f < 5; f++) begin
            frame(16'h8001);
            total += o_err;
            checks += 3;
            if (o_err != 1) begin errors++; $display("FAIL multi_err[%0d]: got %0d want 1", f, o_err); end
            if (o_valid != 0) begin errors++; $display("FAIL multi_valid[%0d]: got %0d want 0", f, o_valid); end
            if (ifc.key_down !== 1'b0) begin errors++; $display("FAIL multi_down[%0d]: got %b want 0", f, ifc.key_down); end
        end
        checks++;
        if (total != 5) begin errors++; $display("FAIL multi_total: got %0d want 5", total); end
    endtask

    task automatic test_random();
        logic [15:0] k;
        for (int n = 0; n < 70; n++) begin
            case ($urandom_range(0, 5))
                0, 1:    k = 16'h0;
                2, 3, 4: k = 16'h1 << $urandom_range(0, 15);
                default: k = (16'h1 << $urandom_range(0, 15)) | (16'h1 << $urandom_range(0, 15));
            endcase
            repeat ($urandom_range(1, 6)) begin
                frame(k);
                checks += 4;
                if (o_valid != int'(e_valid)) begin errors++; $display("FAIL rand_valid: keys %h got %0d want %0d", k, o_valid, e_valid); end
                if (o_err != int'(e_err)) begin errors++; $display("FAIL rand_err: keys %h got %0d want %0d", k, o_err, e_err); end
                if (ifc.key_down !== m_down) begin errors++; $display("FAIL rand_down: keys %h got %b want %b", k, ifc.key_down, m_down); end
                if (ifc.key_code !== m_code) begin errors++; $display("FAIL rand_code: keys %h got %0d want %0d", k, ifc.key_code, m_code); end
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_idle();
        test_press();
        test_bounce();
        test_release();
        test_multi();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
